tea_decrypt_iter: RTL
=====================

// Module: tea_decrypt_iter
// PURPOSE
//  Iterative, parametrised TEA block decryptor. Takes one 64-bit ciphertext block plus a 128-bit key over a
//  valid/ready handshake and runs the full-round TEA inverse (both half-rounds) over several cycles, UNROLL rounds
//  per cycle. Returns the plaintext over a valid/ready handshake. Replaces chains of combinational half-round
//  instances in the decrypt path. One block in flight.
// PARAMETERS
//  ROUNDS  32            number of full TEA rounds; >=1
//  UNROLL  1             full rounds computed per clock; must divide ROUNDS (1,2,4...)
//  DELTA   32'h9E3779B9  TEA key-schedule constant
// PORTS
//  clk        in   1    clock, rising edge
//  rst        in   1    asynchronous, active-high reset
//  in_valid   in   1    input block/key valid
//  in_ready   out  1    block accepted when in_valid & in_ready
//  in_block   in   64   ciphertext; [31:0]=v0, [63:32]=v1
//  key        in   128  k0=[31:0] k1=[63:32] k2=[95:64] k3=[127:96]
//  out_valid  out  1    result valid; held until out_ready
//  out_ready  in   1    downstream accepts when out_valid & out_ready
//  out_block  out  64   plaintext, same packing as in_block
//  busy       out  1    high in RUN or DONE
//  enc_mode   in   1    only with TEA_ENC_MODE_EN (see CONFIGURATION)
// BEHAVIOUR
//  - Reset, async: state=IDLE, in_ready=1, out_valid=0, busy=0, out_block=0. Round counter, sum and key regs are 0.
//  - FSM: IDLE -(in_valid)-> RUN -(last iteration)-> DONE -(out_ready)-> IDLE.
//  - IDLE: in_ready=1. On accept, latch v0, v1 and all 128 key bits. sum := DELTA*ROUNDS mod 2^32
//    (0xC6EF3720 for 32 rounds). cnt := 0.
//  - RUN: each cycle applies UNROLL rounds, in this order, all arithmetic mod 2^32:
//      v1 -= ((v0<<4)+k2) ^ (v0+sum) ^ ((v0>>5)+k3)
//      v0 -= ((v1<<4)+k0) ^ (v1+sum) ^ ((v1>>5)+k1)    (uses the updated v1)
//      sum -= DELTA
//    The shifts are logical. cnt advances by 1 per cycle. After ROUNDS/UNROLL cycles go to DONE.
//  - Latency: accept edge to out_valid high is exactly ROUNDS/UNROLL+1 cycles (33 at defaults).
//  - DONE: out_valid=1 and out_block={v1,v0} stay stable until handshake. in_ready=0 in RUN and DONE.
//    On the handshake cycle, the next edge returns to IDLE. No new accept in the same cycle as the output handshake.
//  - in_block/key changes after accept have no effect. in_valid during RUN/DONE is ignored (not consumed).
//  - Reset asserted mid-RUN or DONE: immediate abort to the reset values. The partial result is never output.
//  - After the final round, sum is 0 (mod 2^32). It is not an output.
// CONFIGURATION
//  TEA_ENC_MODE_EN defined: enc_mode is sampled on accept and stored with the block.
//   - enc_mode=1: encryption. sum starts at 0 and is incremented by DELTA before each round.
//     Order per round: v0 += F(v1,k0,k1,sum), then v1 += F(v0,k2,k3,sum).
//   - enc_mode=0: decryption as above. Latency is the same in both modes.
//  TEA_ENC_MODE_EN undefined: enc_mode port absent; decrypt-only as above.
// TESTING
//  1 key=0, in_block={32'h94BAA940,32'h41EA3A0A} -> out_block=64'h0, out_valid exactly 33 cycles after accept.
//  2 Same as 1 with out_ready=0 for 10 cycles: out_valid and out_block held stable, in_ready=0 throughout,
//    then IDLE 1 cycle after the handshake.
//  3 Reset pulse at cycle 10 of RUN -> out_valid=0, in_ready=1 immediately. Next block decrypts correctly.
//  4 UNROLL=2 and UNROLL=4 builds, 1000 random key/block pairs vs C reference model -> bit-exact results;
//    latency 17 and 9 cycles.
//  5 in_block/key toggled every cycle during RUN, in_valid held high -> result unaffected,
//    the second block is accepted only after return to IDLE.
//  6 TEA_ENC_MODE_EN, enc_mode=1, key=0, block=0 -> {32'h94BAA940,32'h41EA3A0A}.
//    Encrypt-then-decrypt of random data returns the original block.

Source files
------------

// File: rtl/tea_decrypt_iter.sv
// Iterative TEA block decryptor: one 64-bit block in flight, UNROLL full rounds per clock, valid/ready on both sides.
// Optional TEA_ENC_MODE_EN adds an enc_mode input that selects encryption per block.
module tea_decrypt_iter #(
  parameter int          ROUNDS = 32,
  parameter int          UNROLL = 1,
  parameter logic [31:0] DELTA  = 32'h9E3779B9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [63:0]  in_block,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [63:0]  out_block,
`ifdef TEA_ENC_MODE_EN
  input  logic         enc_mode,
`endif
  output logic         busy
);

  localparam int          ITERS    = ROUNDS / UNROLL;
  localparam int          CW       = (ITERS > 1) ? $clog2(ITERS) : 1;
  localparam logic [CW-1:0] LAST   = CW'(ITERS - 1);
  localparam logic [31:0] SUM_INIT = 32'(DELTA * 32'(ROUNDS));

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_n;
  logic [31:0]   v0, v1, sum;
  logic [31:0]   v0_n, v1_n, sum_n;
  logic [127:0]  key_q;
  logic [CW-1:0] cnt;
  logic          enc_q;

  function automatic logic [31:0] f(input logic [31:0] v, input logic [31:0] ka,
                                    input logic [31:0] kb, input logic [31:0] s);
    return ((v << 4) + ka) ^ (v + s) ^ ((v >> 5) + kb);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_n = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (cnt == LAST) state_n = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // UNROLL rounds chained combinationally; each round sees the previous round's halves and sum.
  always_comb begin
    v0_n  = v0;
    v1_n  = v1;
    sum_n = sum;
    for (int r = 0; r < UNROLL; r++) begin
      if (enc_q) begin
        sum_n = sum_n + DELTA;
        v0_n  = v0_n + f(v1_n, key_q[31:0], key_q[63:32], sum_n);
        v1_n  = v1_n + f(v0_n, key_q[95:64], key_q[127:96], sum_n);
      end else begin
        v1_n  = v1_n - f(v0_n, key_q[95:64], key_q[127:96], sum_n);
        v0_n  = v0_n - f(v1_n, key_q[31:0], key_q[63:32], sum_n);
        sum_n = sum_n - DELTA;
      end
    end
  end

`ifdef TEA_ENC_MODE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                           enc_q <= 1'b0;
    else if (state == IDLE && in_valid) enc_q <= enc_mode;
  end
`else
  assign enc_q = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v0    <= '0;
      v1    <= '0;
      sum   <= '0;
      key_q <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            v0    <= in_block[31:0];
            v1    <= in_block[63:32];
            key_q <= key;
            cnt   <= '0;
`ifdef TEA_ENC_MODE_EN
            sum   <= enc_mode ? 32'h0 : SUM_INIT;
`else
            sum   <= SUM_INIT;
`endif
          end
        end
        RUN: begin
          v0  <= v0_n;
          v1  <= v1_n;
          sum <= sum_n;
          cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign out_block = {v1, v0};

endmodule
